// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game button front-end.
package genius_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    localparam logic [1:0] BTN_CODE_NONE = 2'd0;
    localparam logic [1:0] BTN_CODE_0    = 2'd1;
    localparam logic [1:0] BTN_CODE_1    = 2'd2;
    localparam logic [1:0] BTN_CODE_2    = 2'd3;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int REPEAT_CYCLES_DEF   = 25000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-FF synchronizer (inverted to active-high) plus a debounce
// counter that flips the accepted level after DEBOUNCE_CYCLES of disagreement.
module btn_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= ~btn_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_press_encoder.sv
// Button conditioning and press encoder feeding the game FSM.
// Optional auto-repeat while a single button is held: define BTN_REPEAT_EN.
module btn_press_encoder
    import genius_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic             press,
    output logic [1:0]       press_code,
    output logic             multi_press,
    output logic [N_BTN-1:0] btn_level,
    output logic             busy
);

    localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1;

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_cell
            btn_debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_cell (
                .clock (clock),
                .reset (reset),
                .btn_n (btn_n[g]),
                .level (btn_level[g])
            );
        end
    endgenerate

    logic       any_held, single;
    logic [1:0] enc;

    always_comb begin
        enc = BTN_CODE_NONE;
        for (int i = N_BTN - 1; i >= 0; i--)
            if (btn_level[i]) enc = 2'(i + 1);
    end

    assign any_held = (btn_level != '0);
    assign single   = any_held && ((btn_level & (btn_level - N_BTN'(1))) == '0);

    btn_state_e state, state_nx;
    logic       rep_fire;

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_MAX  = '1;
    logic [CNT_W-1:0] rep_cnt;

    assign rep_fire = (state == ST_HOLD) && single && (rep_cnt >= REP_LAST);

    // Restarts on accept, on every repeat, and whenever the hold is not a lone button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rep_cnt <= '0;
        else if (state == ST_IDLE || !single || rep_fire)
            rep_cnt <= '0;
        else if (rep_cnt != REP_MAX)
            rep_cnt <= rep_cnt + 1'b1;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE:   state_nx = any_held ? ST_HOLD : ST_IDLE;
            ST_HOLD: begin
                if (!any_held)     state_nx = ST_IDLE;
                else if (rep_fire) state_nx = ST_REPEAT;
                else               state_nx = ST_HOLD;
            end
`ifdef BTN_REPEAT_EN
            ST_REPEAT: state_nx = any_held ? ST_HOLD : ST_IDLE;
`endif
            default:   state_nx = ST_IDLE;
        endcase
    end

    logic       press_d, multi_d;
    logic [1:0] code_d;

    always_comb begin
        press_d = 1'b0;
        multi_d = 1'b0;
        code_d  = press_code;
        if (state == ST_IDLE && any_held) begin
            if (single) begin
                press_d = 1'b1;
                code_d  = enc;
            end else begin
                multi_d = 1'b1;
                code_d  = BTN_CODE_NONE;
            end
        end else if (rep_fire && any_held) begin
            press_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press       <= 1'b0;
            multi_press <= 1'b0;
            press_code  <= BTN_CODE_NONE;
        end else begin
            press       <= press_d;
            multi_press <= multi_d;
            press_code  <= code_d;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_btn_press_encoder.sv
// Scoreboard bench for btn_press_encoder: reference model queues expected pulses, monitor checks them.
module tb_btn_press_encoder;

    localparam int N = 3;
    localparam int D = 4;
    localparam int R = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_n = '1;
    logic         press, multi_press, busy;
    logic [1:0]   press_code;
    logic [N-1:0] btn_level;

    always #5 clock = ~clock;

    btn_press_encoder #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_n       (btn_n),
        .press       (press),
        .press_code  (press_code),
        .multi_press (multi_press),
        .btn_level   (btn_level),
        .busy        (busy)
    );

    typedef struct {
        int         cyc;
        logic       multi;
        logic [1:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    // Reference model: levels flip after D consecutive disagreeing samples seen
    // through two sync stages; the game side accepts the first nonzero level set.
    logic [N-1:0] m_hist0 = '0, m_hist1 = '0, m_lvl = '0;
    int           m_run[N];
    bit           m_hold = 1'b0;
    int           m_age  = 0;
    logic [1:0]   m_code = 2'd0;

    function automatic int popc(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [1:0] code_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return 2'(i + 1);
        return 2'd0;
    endfunction

    task automatic push_ev(input int c, input logic m, input logic [1:0] code);
        ev_t e;
        e.cyc = c; e.multi = m; e.code = code;
        exp_q.push_back(e);
    endtask

    always @(posedge clock or negedge reset) begin : model
        logic [N-1:0] old;
        if (!reset) begin
            m_hist0 = '0; m_hist1 = '0; m_lvl = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_hold = 1'b0; m_age = 0; m_code = 2'd0;
            exp_q.delete();
        end else begin
            cyc++;
            old = m_lvl;
            if (!m_hold) begin
                if (old != '0) begin
                    m_hold = 1'b1;
                    m_age  = 0;
                    if (popc(old) == 1) begin
                        m_code = code_of(old);
                        push_ev(cyc, 1'b0, m_code);
                    end else begin
                        m_code = 2'd0;
                        push_ev(cyc, 1'b1, 2'd0);
                    end
                end
            end else if (old == '0) begin
                m_hold = 1'b0;
            end
`ifdef BTN_REPEAT_EN
            else if (popc(old) == 1) begin
                m_age++;
                if (m_age == R) begin
                    m_age = 0;
                    push_ev(cyc, 1'b0, m_code);
                end
            end else begin
                m_age = 0;
            end
`endif
            for (int i = 0; i < N; i++) begin
                if (m_hist1[i] != old[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_hist1 = m_hist0;
            m_hist0 = ~btn_n;
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        ev_t e;
        if (reset) begin
            chk("level", 4'(btn_level), 4'(m_lvl));
            chk("busy", 4'(busy), 4'(m_hold));
            chk("code", 4'(press_code), 4'(m_code));
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missed_pulse cyc=%0d got=none want=multi%0d/code%0d@%0d",
                         cyc, e.multi, e.code, e.cyc);
            end
            if (press || multi_press) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse cyc=%0d got=press%0d/multi%0d want=none",
                             cyc, press, multi_press);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.multi !== multi_press || press !== !e.multi
                        || e.code !== press_code) begin
                        n_bad++;
                        $display("FAIL pulse cyc=%0d got=press%0d/multi%0d/code%0d want=multi%0d/code%0d@%0d",
                                 cyc, press, multi_press, press_code, e.multi, e.code, e.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic [N-1:0] v, input int n);
        @(negedge clock);
        btn_n = v;
        wait_cyc(n);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_press"}, 4'(press), 4'd0);
        chk({nm, "_multi"}, 4'(multi_press), 4'd0);
        chk({nm, "_code"},  4'(press_code), 4'd0);
        chk({nm, "_level"}, 4'(btn_level), 4'd0);
        chk({nm, "_busy"},  4'(busy), 4'd0);
    endtask

    initial begin
        // reset held with btn0 pressed, then buttons released before reset lifts
        btn_n = 3'b110;
        wait_cyc(5);
        chk_reset_outputs("rst");
        btn_n = 3'b111;
        wait_cyc(2);
        #2 reset = 1'b1;
        wait_cyc(20);

        drive(3'b101, 20);            // single press btn1
        drive(3'b111, 20);

        for (int k = 0; k < 6; k++)   // bounce on btn0, then stable
            drive((k % 2 == 0) ? 3'b110 : 3'b111, 2);
        drive(3'b110, 20);
        drive(3'b111, 20);

        drive(3'b010, 20);            // btn0 + btn2 simultaneously
        drive(3'b111, 20);
        drive(3'b011, 20);            // btn2 alone
        drive(3'b111, 20);

        drive(3'b110, 20);            // btn0 held, then btn1 added
        drive(3'b100, 20);
        drive(3'b101, 20);
        drive(3'b111, 20);

        drive(3'b011, 56);            // long hold on btn2
        drive(3'b111, 20);

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 2) == 0) drive(3'b111, $urandom_range(4, 14));
            else                           drive(3'($urandom_range(0, 7)), $urandom_range(1, 12));
        end

        // asynchronous reset while a button is held
        drive(3'b110, 12);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        btn_n = 3'b111;
        wait_cyc(3);
        #2 reset = 1'b1;
        drive(3'b011, 20);
        drive(3'b111, 40);

        chk("pending_events", 4'(exp_q.size() > 8 ? 8 : exp_q.size()), 4'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
